// File: rtl/disp_pkg.sv
// Shared digit-code types and constants for the display scan path.
// Also provides the leading-zero blanking helper used by the scan controller.
package disp_pkg;

  localparam int NDIG    = 4;
  localparam int DIGIT_W = 5;
  localparam int DP_BIT  = 4;
  localparam int HEX_MSB = 3;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef digit_t [NDIG-1:0]  digits_t;

  // Bits that must be zero for a digit to count as a leading zero (hex field only).
  localparam digit_t LZ_MASK = digit_t'((1 << (HEX_MSB + 1)) - 1) & ~digit_t'(1 << DP_BIT);

  // Bit i set when digits NDIG-1 down to i all have zero hex fields; digit 0 is never blanked.
  function automatic logic [NDIG-1:0] lz_mask(input digits_t dg);
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above = zero_above && ((dg[i] & LZ_MASK) == '0);
      lz_mask[i] = zero_above;
    end
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Slot/select timebase: cnt walks 0..SCAN_DIV-1 per digit slot, s steps per slot.
// Latency: s registered; guard and frame_tick are combinational from the counters. No backpressure.
module disp_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] s,
  output logic       guard,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap       = (cnt == CNT_LAST);
  assign guard      = (32'(cnt) < GUARD);
  assign frame_tick = wrap && (s == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      s   <= 2'd0;
    end else if (wrap) begin
      cnt <= '0;
      s   <= s + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit scan controller: tear-free digit registers, guarded anode drive, LZ blanking, blink.
// Latency: an lags the slot counter by 1 cycle; loads land at the next frame boundary. No backpressure.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 500,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [19:0] din,
  input  logic        lz_en,
  input  logic [3:0]  blink_mask,
  output logic        load_ack,
  output logic [4:0]  d0,
  output logic [4:0]  d1,
  output logic [4:0]  d2,
  output logic [4:0]  d3,
  output logic [1:0]  s,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [1:0]      sel;
  logic            guard;
  logic            frame_tick;
  digits_t         disp;
  digits_t         pend;
  logic            pend_vld;
  logic [BW-1:0]   bcnt;
  logic            bphase;
  logic [NDIG-1:0] blank;
  logic [3:0]      an_nxt;

  disp_tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (sel),
    .guard      (guard),
    .frame_tick (frame_tick)
  );

  assign s  = sel;
  assign d0 = disp[0];
  assign d1 = disp[1];
  assign d2 = disp[2];
  assign d3 = disp[3];

  assign blank = (lz_en ? lz_mask(disp) : '0) | (bphase ? blink_mask : '0);

  always_comb begin
    an_nxt = 4'b1111;
    if (!guard && !blank[sel]) an_nxt = ~(4'b0001 << sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an       <= 4'b1111;
      frame    <= 1'b0;
      load_ack <= 1'b0;
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      bcnt     <= '0;
      bphase   <= 1'b0;
    end else begin
      an       <= an_nxt;
      frame    <= frame_tick;
      load_ack <= 1'b0;
      // A load on the boundary cycle bypasses the buffer and supersedes anything pending.
      if (frame_tick && load) begin
        disp     <= din;
        pend_vld <= 1'b0;
        load_ack <= 1'b1;
      end else if (frame_tick && pend_vld) begin
        disp     <= pend;
        pend_vld <= 1'b0;
        load_ack <= 1'b1;
      end else if (load) begin
        pend     <= din;
        pend_vld <= 1'b1;
      end
      if (frame_tick) begin
        if (bcnt == BLINK_LAST) begin
          bcnt   <= '0;
          bphase <= ~bphase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Four-digit time-multiplexed display scan controller, sitting directly upstream of the 5-bit 4:1 digit mux in the display path. Holds the four 5-bit digit codes in tear-free registers, drives the mux select and the active-low digit anodes, and inserts a dead-time guard at each digit switch to prevent ghosting. Supports leading-zero suppression and per-digit blinking. The game logic writes new digit values through a load/ack handshake.

## Interface
- `SCAN_DIV`, 50000: clocks per digit slot; must be ≥ 2.
- `GUARD`, 500: clocks at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < SCAN_DIV.
- `BLINK_FRAMES`, 128: full scan frames per blink half-period; must be ≥ 1.
- `clk` in 1: system clock; the block uses this single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: one-cycle write strobe for `din`.
- `din` in 20: packed digit codes, digit i at `[5i+4:5i]`. Digit 3 is the leftmost (most significant) digit. Code bit 4 is the decimal point; bits 3:0 are the hex value.
- `lz_en` in 1: leading-zero suppression enable.
- `blink_mask` in 4: bit i set means digit i blinks.
- `load_ack` out 1: one-cycle pulse when the loaded value becomes visible.
- `d0`, `d1`, `d2`, `d3` out 5 each: displayed digit codes, routed to mux inputs I0 through I3.
- `s` out 2: mux select, equal to the current digit index.
- `an` out 4: active-low anodes; bit i drives digit i.
- `frame` out 1: one-cycle pulse at the end of each full scan frame.

## Operation
- **Slot counter `cnt`:**
  - Counts 0 to SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and `s` increments modulo 4.
- **Frame boundary:** the cycle where `cnt`=SCAN_DIV-1 and `s`=3.
  - `frame` pulses on that cycle (registered, so it is visible in the following cycle).
- **Phases within each slot:**
  - GUARD phase (`cnt` < GUARD): `an`=4'b1111.
  - ON phase: `an`=~(4'b0001<<`s`), unless digit `s` is blanked, in which case `an`=4'b1111.
- **Blanking of digit i.** The digit is blanked if either condition holds:
  - Leading zero: `lz_en`=1, i ≥ 1, and the hex fields of digits 3 down to i are all 0. Digit 0 is never lz-blanked. The decimal point does not defeat suppression.
  - Blink: blink phase = 1 and `blink_mask[i]`=1.
- **Blink counter:**
  - Counts frame boundaries.
  - After BLINK_FRAMES boundaries it clears and toggles the blink phase.
- **Load path:**
  - A `load` pulse captures `din` into a pending buffer and sets `pend_v`.
  - A later `load` before transfer overwrites the buffer; the latest value wins.
  - At a frame boundary with `pend_v`=1, the pending buffer moves to `d0`..`d3`, `pend_v` clears, and `load_ack` pulses.
  - If `load` coincides with a frame boundary, `din` goes directly to `d0`..`d3`, `load_ack` pulses, and `pend_v` ends at 0.
- `lz_en` and `blink_mask` are sampled combinationally every cycle; no handshake is required.

## Timing
- **Reset values:** `cnt`=0, `s`=0, `an`=4'b1111, `d0`..`d3`=0, `pend_v`=0, `load_ack`=0, `frame`=0, blink phase=0, blink counter=0.
- **Output registers:** `an`, `s`, `load_ack`, and `frame` are registered; anode changes lag the `cnt` transition by 1 cycle.
- **Load-to-visible latency:** 1 to 4·SCAN_DIV cycles, always aligned to a frame boundary. Digits never update mid-frame.
- **Reset mid-frame:** reset asserted mid-frame returns to the reset state immediately and discards any pending load.
- **Counter width:** `cnt` is $clog2(SCAN_DIV) bits. The blink counter is $clog2(BLINK_FRAMES+1) bits.
- **Wrap behaviour:** all counters wrap without saturation.
- **GUARD=0:** there is no dead time, and `an` switches directly between adjacent digits.

## Structure
- **Package `disp_pkg`:**
  - Constants NDIG=4 and DIGIT_W=5.
  - Field positions DP_BIT=4 and HEX_MSB=3.
  - A digit-code typedef.
- **Sub-module `disp_tick_gen`:** the slot counter plus select counter, producing `s`, the guard flag, and the frame-boundary strobe.
- **Parent module:** load buffer, blink logic, blanking logic, and anode generation.

## Test plan
Bench parameters: SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
- **Reset and scan:** release reset, no load. Expect `an`=1111 for cycles 0–2, then 1110 for cycles 3–8, then 1111 for 2 cycles, then 1101, and so on. `s` steps 0,1,2,3,0. `frame` pulses every 32 cycles.
- **Load handshake:** `load` with `din`=20'h1_2345 (packed) mid-frame. `d*` stay 0 until the frame boundary, then update. `load_ack` pulses exactly once.
- **Double load:** two loads, A then B, in one frame. Only B appears, and `load_ack` pulses once. A `load` on the boundary cycle with `din` C displays C immediately.
- **Leading-zero suppression:** with `lz_en`=1 and hex digits {3:0, 2:0, 1:5, 0:0}, digits 3 and 2 anodes stay high and digits 1 and 0 light. With all hex digits 0, only digit 0 lights.
- **Blink:** `blink_mask`=4'b0100. Digit 2 is lit for 2 frames, dark for 2 frames, and repeats; other digits are unaffected.
- **Reset mid-operation:** assert `rst_n`=0 during slot 2 with a load pending. Expect all outputs at reset values within the same cycle, and no `load_ack` after release.
